// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - daisy-chain interrupt arbiter presenting one winner to the CPU
module interrupt_controller #(
  parameter int N_DEV    = 4,
  parameter int MAX_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DEV-1:0]     hasInterrupt,
  input  logic [N_DEV-1:0]     me,
  input  logic [8*N_DEV-1:0]   trapTypeIn,
  input  logic [4*N_DEV-1:0]   levelIn,
  input  logic [3:0]           cpuLevel,
  input  logic                 intAck,
  output logic                 PI,
  output logic                 handledO,
  output logic                 irq,
  output logic [7:0]           vector,
  output logic [3:0]           irqLevel,
  output logic [7:0]           spuriousCount,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, POLL, CHECK, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  waitCnt, waitCnt_nxt;
  logic        pi_nxt, handled_nxt, irq_nxt;
  logic [7:0]  vector_nxt, spur_nxt;
  logic [3:0]  level_nxt;
  logic [7:0]  win_trap;
  logic [3:0]  win_level;

  // Scan high to low so the lowest selected index is the one left standing.
  always_comb begin
    win_trap  = '0;
    win_level = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (me[i]) begin
        win_trap  = trapTypeIn[8*i +: 8];
        win_level = levelIn[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    waitCnt_nxt = waitCnt;
    pi_nxt      = PI;
    handled_nxt = handledO;
    irq_nxt     = irq;
    vector_nxt  = vector;
    level_nxt   = irqLevel;
    spur_nxt    = spuriousCount;
    case (state)
      IDLE: begin
        if (|hasInterrupt) begin
          pi_nxt      = 1'b1;
          waitCnt_nxt = '0;
          state_nxt   = POLL;
        end
      end
      POLL: begin
        waitCnt_nxt = waitCnt + 8'd1;
        if (|me) begin
          vector_nxt = win_trap;
          level_nxt  = win_level;
          state_nxt  = CHECK;
        end else if (waitCnt == 8'(MAX_WAIT - 1)) begin
          pi_nxt    = 1'b0;
          spur_nxt  = (spuriousCount == 8'hff) ? spuriousCount : spuriousCount + 8'd1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (irqLevel > cpuLevel) begin
          irq_nxt   = 1'b1;
          state_nxt = REQ;
        end else begin
          // Not retired: the device stays pending and is polled again from IDLE.
          pi_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (intAck) begin
          irq_nxt     = 1'b0;
          pi_nxt      = 1'b0;
          handled_nxt = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        handled_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      waitCnt       <= '0;
      PI            <= 1'b0;
      handledO      <= 1'b0;
      irq           <= 1'b0;
      vector        <= '0;
      irqLevel      <= '0;
      spuriousCount <= '0;
    end else begin
      state         <= state_nxt;
      waitCnt       <= waitCnt_nxt;
      PI            <= pi_nxt;
      handledO      <= handled_nxt;
      irq           <= irq_nxt;
      vector        <= vector_nxt;
      irqLevel      <= level_nxt;
      spuriousCount <= spur_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized transaction-level check of interrupt_controller
module tb_interrupt_controller;
  localparam int N_DEV    = 4;
  localparam int MAX_WAIT = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_DEV-1:0]     hasInterrupt;
  logic [N_DEV-1:0]     me;
  logic [8*N_DEV-1:0]   trapTypeIn;
  logic [4*N_DEV-1:0]   levelIn;
  logic [3:0]           cpuLevel;
  logic                 intAck;
  logic                 PI, handledO, irq, busy;
  logic [7:0]           vector, spuriousCount;
  logic [3:0]           irqLevel;

  interrupt_controller #(.N_DEV(N_DEV), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .hasInterrupt(hasInterrupt), .me(me),
    .trapTypeIn(trapTypeIn), .levelIn(levelIn), .cpuLevel(cpuLevel),
    .intAck(intAck), .PI(PI), .handledO(handledO), .irq(irq),
    .vector(vector), .irqLevel(irqLevel), .spuriousCount(spuriousCount),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_spur = 0;
  logic [7:0] trap [N_DEV];
  logic [3:0] lvl  [N_DEV];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < N_DEV; i++) begin
      trapTypeIn[8*i +: 8] = trap[i];
      levelIn[4*i +: 4]    = lvl[i];
    end
  endtask

  // PI already observed high for one cycle; count the rest and expect a spurious tick.
  task automatic finish_timeout();
    int cnt = 1;
    for (int g = 0; g < 4 * MAX_WAIT; g++) begin
      step();
      if (PI) cnt++;
      else break;
    end
    check("pi_width", cnt, MAX_WAIT);
    exp_spur = (exp_spur >= 255) ? 255 : exp_spur + 1;
    check("spurious", spuriousCount, exp_spur);
    check("idle_after_timeout", busy, 0);
  endtask

  task automatic do_poll(input logic [N_DEV-1:0] pend, input logic [N_DEV-1:0] mask,
                         input int d, input logic [3:0] cpu, input bit repoll,
                         input int ackdly, input bit ack_noise);
    int k = 0;
    pack();
    cpuLevel     = cpu;
    me           = '0;
    hasInterrupt = pend;
    step();
    check("poll_pi", PI, 1);
    check("poll_busy", busy, 1);
    hasInterrupt = '0;
    if (mask == '0) begin
      finish_timeout();
      return;
    end
    for (int j = 0; j < d; j++) begin
      intAck = ack_noise;
      step();
      if (ack_noise) check("ack_in_poll", {PI, handledO, irq}, 3'b100);
    end
    intAck = 1'b0;
    me = mask;
    step();
    me = '0;
    for (int i = N_DEV - 1; i >= 0; i--) if (mask[i]) k = i;
    check("vector", vector, trap[k]);
    check("irqLevel", irqLevel, lvl[k]);
    check("check_irq", irq, 0);
    step();
    if (lvl[k] > cpu) begin
      check("irq_up", irq, 1);
      for (int j = 0; j < ackdly; j++) begin
        cpuLevel = 4'($urandom);
        step();
        check("irq_held", irq, 1);
        check("vector_held", vector, trap[k]);
      end
      intAck = 1'b1;
      step();
      intAck = 1'b0;
      check("ack_irq", irq, 0);
      check("ack_handled", handledO, 1);
      check("ack_pi", PI, 0);
      step();
      check("handled_width", handledO, 0);
      check("done_idle", busy, 0);
    end else begin
      check("noirq_irq", irq, 0);
      check("noirq_pi", PI, 0);
      check("noirq_handled", handledO, 0);
      if (repoll) begin
        hasInterrupt = pend;
        step();
        hasInterrupt = '0;
        check("repoll_pi", PI, 1);
        check("repoll_handled", handledO, 0);
        finish_timeout();
      end
    end
  endtask

  initial begin
    logic [N_DEV-1:0] m, p;
    reset = 1'b1; hasInterrupt = '0; me = '0; trapTypeIn = '0; levelIn = '0;
    cpuLevel = '0; intAck = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin trap[i] = '0; lvl[i] = '0; end
    step(); step();
    reset = 1'b0;
    check("rst_outputs", {PI, handledO, irq, busy}, 4'b0000);
    check("rst_vector", vector, 0);
    check("rst_spur", spuriousCount, 0);

    // Device 2, level 5 over cpu 3.
    trap[2] = 8'h30; lvl[2] = 4'd5;
    do_poll(4'b0100, 4'b0100, 2, 4'd3, 1'b0, 2, 1'b1);

    // Simultaneous me[1]/me[3]: lowest index wins.
    trap[1] = 8'h11; lvl[1] = 4'd7; trap[3] = 8'h33; lvl[3] = 4'd9;
    do_poll(4'b1010, 4'b1010, 0, 4'd0, 1'b0, 0, 1'b0);

    // Equal level: no irq, re-poll while still pending.
    trap[0] = 8'h44; lvl[0] = 4'd4;
    do_poll(4'b0001, 4'b0001, 1, 4'd4, 1'b1, 0, 1'b0);

    // me in the timeout cycle beats the timeout.
    do_poll(4'b0001, 4'b0001, MAX_WAIT - 1, 4'd0, 1'b0, 1, 1'b0);

    // intAck in IDLE is ignored.
    intAck = 1'b1;
    step(); step();
    intAck = 1'b0;
    check("ack_in_idle", {busy, handledO, irq, PI}, 4'b0000);

    // Spurious polls up to and past saturation.
    for (int r = 0; r < 300; r++) do_poll(4'b0010, '0, 0, 4'd0, 1'b0, 0, 1'b0);

    // Reset mid-REQ.
    trap[3] = 8'h5a; lvl[3] = 4'd15;
    pack();
    cpuLevel = 4'd1; hasInterrupt = 4'b1000;
    step();
    hasInterrupt = '0; me = 4'b1000;
    step();
    me = '0;
    step();
    check("pre_reset_irq", irq, 1);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    exp_spur = 0;
    check("mid_rst_outputs", {PI, handledO, irq, busy}, 4'b0000);
    check("mid_rst_vector", vector, 0);
    check("mid_rst_level", irqLevel, 0);
    check("mid_rst_spur", spuriousCount, 0);

    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < N_DEV; i++) begin
        trap[i] = 8'($urandom);
        lvl[i]  = 4'($urandom);
      end
      m = ($urandom_range(0, 3) == 0) ? '0 : N_DEV'($urandom_range(1, (1 << N_DEV) - 1));
      p = (m == '0) ? N_DEV'($urandom_range(1, (1 << N_DEV) - 1)) : m;
      do_poll(p, m, $urandom_range(0, MAX_WAIT - 1), 4'($urandom), 1'($urandom),
              $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sits directly downstream of the device interrupt daisy chain and consumes its hasInterrupt, me, trapType and interruptLevel outputs.
- Drives the chain-head PI and handled lines.
- Arbitrates a single winner, compares its level with the CPU's current level, and presents irq/vector/level to the CPU.
- On acknowledge it retires the request with a handled pulse.

Parameters:
N_DEV, 4, number of devices on the chain (1..16)
MAX_WAIT, 16, cycles PI is held waiting for a me response before declaring a spurious poll (2..255)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
hasInterrupt  input  N_DEV  per-device pending flags
me  input  N_DEV  per-device "selected" flags from chain
trapTypeIn  input  8*N_DEV  device i trap type in bits [8i+7:8i]
levelIn  input  4*N_DEV  device i level in bits [4i+3:4i]
cpuLevel  input  4  CPU's current interrupt level
intAck  input  1  CPU acknowledge, sampled only in REQ
PI  output  1  priority-in to chain head
handledO  output  1  handled pulse to chain head
irq  output  1  interrupt request to CPU
vector  output  8  winner trap type
irqLevel  output  4  winner level
spuriousCount  output  8  saturating count of timed-out polls
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high; clears all state from any state mid-operation): state=IDLE; PI, handledO and irq = 0; vector=0, irqLevel=0, spuriousCount=0, waitCnt=0.
- All outputs are registered. busy is decoded from the state register.
- States: IDLE, POLL, CHECK, REQ, DONE.
- IDLE:
  - If |hasInterrupt: PI<=1, waitCnt<=0, go to POLL.
  - Else remain.
- POLL:
  - PI held 1; waitCnt increments each cycle.
  - If |me: pick the lowest set index k (priority encoder; simultaneous me bits resolve to lowest index), capture vector<=trapTypeIn[k], irqLevel<=levelIn[k], go to CHECK.
  - Else if waitCnt==MAX_WAIT-1: PI<=0, spuriousCount<=spuriousCount+1 (saturating at 255), go to IDLE.
  - me takes priority over timeout in the same cycle.
- CHECK (one cycle):
  - If irqLevel > cpuLevel (unsigned, strict): irq<=1, go to REQ.
  - Else: PI<=0, go to IDLE (no handled pulse; device keeps pending and is re-polled from IDLE the next cycle it is still pending).
- REQ:
  - irq, vector and irqLevel are held stable.
  - cpuLevel changes are ignored.
  - On intAck: irq<=0, PI<=0, handledO<=1, go to DONE.
- DONE: handledO<=0, go to IDLE. handledO is exactly one cycle wide.
- intAck in any state other than REQ is ignored.
- hasInterrupt dropping during POLL does not abort the poll; the timeout path covers it.
- vector and irqLevel retain their last captured values in IDLE.
- Minimum latency, device pending to irq high: IDLE→POLL (1), first me seen (≥1 depending on chain depth), CHECK (1).

Test Plan:
- Reset held 2 cycles mid-REQ with irq=1 → next cycle state=IDLE, irq=0, PI=0, vector=0, spuriousCount=0, busy=0.
- Device 2 pending (trap 0x30, level 5), cpuLevel=3, me[2] rises 2 cycles after PI → CHECK next cycle, irq=1, vector=0x30, irqLevel=5. intAck → irq=0, handledO=1 for exactly 1 cycle, then IDLE.
- me[1] and me[3] rise in the same cycle (trap 0x11/lvl 7, trap 0x33/lvl 9), cpuLevel=0 → vector=0x11, irqLevel=7.
- Winner level 4, cpuLevel=4 → no irq, PI drops after CHECK, handledO stays 0, re-poll begins the following cycle while hasInterrupt remains set.
- hasInterrupt pulsed with no me response, MAX_WAIT=16 → PI high exactly 16 cycles, spuriousCount increments 0→1. Repeat 300 times → saturates at 255.
- intAck asserted in IDLE and POLL → ignored: no handledO, no state change. Level drop of cpuLevel during REQ → irq stays 1 until intAck.
